// File: rtl/lb_fifo_csr_pkg.sv
// Package for lb_fifo_csr: register offsets, STATUS/CTRL/IRQ_EN bit positions,
// field widths and the offset decoder shared by the CSR block.
// Optional interrupt feature is enabled with macro LB_FIFO_CSR_IRQ_EN.
package lb_fifo_csr_pkg;

    // Register offsets, decoded from address bits [7:0]
    localparam logic [7:0] OFF_TXDATA = 8'h00;
    localparam logic [7:0] OFF_RXDATA = 8'h04;
    localparam logic [7:0] OFF_STATUS = 8'h08;
    localparam logic [7:0] OFF_CTRL   = 8'h0C;
    localparam logic [7:0] OFF_IRQ_EN = 8'h10;
    localparam int         OFF_W      = 8;

    // STATUS layout
    localparam int ST_TX_COUNT_LSB = 0;
    localparam int ST_RX_COUNT_LSB = 8;
    localparam int ST_COUNT_W      = 8;
    localparam int ST_TX_FULL      = 16;
    localparam int ST_RX_EMPTY     = 17;
    localparam int ST_RXUF         = 18;
    localparam int ST_RXOF         = 19;
    localparam int ST_WERR         = 20;
    localparam int ST_W            = 21;

    // CTRL layout
    localparam int CTRL_TX_FLUSH = 0;
    localparam int CTRL_RX_FLUSH = 1;
    localparam int CTRL_RX_EN    = 2;

    // IRQ_EN layout
    localparam int IRQ_RX_NOT_EMPTY = 0;
    localparam int IRQ_TX_EMPTY     = 1;
    localparam int IRQ_ERR          = 2;
    localparam int IRQ_EN_W         = 3;

    typedef enum logic [2:0] {
        REG_TXDATA,
        REG_RXDATA,
        REG_STATUS,
        REG_CTRL,
        REG_IRQ_EN,
        REG_NONE
    } reg_sel_e;

    // Map a byte offset onto a register select; anything unmapped is REG_NONE
    function automatic reg_sel_e decode_offset(input logic [OFF_W-1:0] off);
        reg_sel_e sel;
        case (off)
            OFF_TXDATA: sel = REG_TXDATA;
            OFF_RXDATA: sel = REG_RXDATA;
            OFF_STATUS: sel = REG_STATUS;
            OFF_CTRL:   sel = REG_CTRL;
            OFF_IRQ_EN: sel = REG_IRQ_EN;
            default:    sel = REG_NONE;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/lb_fifo_sync.sv
// Synchronous FIFO with occupancy count, full/empty flags and a flush input.
// Flush dominates push/pop; a push into a full FIFO is taken only when a pop
// happens in the same cycle. DEPTH must be a power of two so that the
// pointers wrap naturally.
module lb_fifo_sync #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     push,
    input  logic [DATA_W-1:0]        push_data,
    input  logic                     pop,
    output logic [DATA_W-1:0]        head_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              push_ok;
    logic              pop_ok;

    assign full      = (count_q == CNT_W'(DEPTH));
    assign empty     = (count_q == '0);
    assign count     = count_q;
    assign head_data = mem_q[rd_ptr_q];

    // Next-state for pointers and count; flush clears everything
    always_comb begin
        pop_ok   = pop && !empty;
        push_ok  = push && (!full || pop_ok);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_ok) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (pop_ok) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Pointer and count registers
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; a write that coincides with flush or reset is dropped
    always_ff @(posedge clk) begin
        if (!rst && !flush && push_ok) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

endmodule

// File: rtl/lb_fifo_csr.sv
// lb_fifo_csr: local-bus CSR block fronting a TX FIFO (bus -> tx stream) and
// an RX FIFO (rx stream -> bus), with STATUS sticky error flags and CTRL
// flush/enable bits. Reads answer exactly one cycle after lb_ren is accepted.
// Define LB_FIFO_CSR_IRQ_EN to add the IRQ_EN register and the irq output.
module lb_fifo_csr
    import lb_fifo_csr_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_W-1:0]     lb_waddr,
    input  logic [DATA_W-1:0]     lb_wdata,
    input  logic                  lb_wen,
    input  logic [DATA_W/8-1:0]   lb_wstrb,
    output logic                  lb_wready,
    input  logic [ADDR_W-1:0]     lb_raddr,
    input  logic                  lb_ren,
    output logic [DATA_W-1:0]     lb_rdata,
    output logic                  lb_rvalid,
    output logic [DATA_W-1:0]     tx_data,
    output logic                  tx_valid,
    input  logic                  tx_ready,
    input  logic [DATA_W-1:0]     rx_data,
    input  logic                  rx_valid,
    output logic                  rx_ready
`ifdef LB_FIFO_CSR_IRQ_EN
    ,
    output logic                  irq
`endif
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    reg_sel_e          wr_sel;
    reg_sel_e          rd_sel;
    logic              wr_fire;
    logic              strb_all;
    logic              ctrl_wr;
    logic              rd_accept;

    logic              tx_push, tx_pop, tx_flush;
    logic              tx_full, tx_empty;
    logic [CNT_W-1:0]  tx_count;
    logic [DATA_W-1:0] tx_head;

    logic              rx_push, rx_pop, rx_flush;
    logic              rx_full, rx_empty;
    logic [CNT_W-1:0]  rx_count;
    logic [DATA_W-1:0] rx_head;

    logic              rx_en_q, rx_en_d;
    logic              rxuf_q, rxuf_d;
    logic              rxof_q, rxof_d;
    logic              werr_q, werr_d;
    logic              lb_rvalid_q, lb_rvalid_d;
    logic [DATA_W-1:0] lb_rdata_q, lb_rdata_d;
    logic [DATA_W-1:0] status_word;
    logic [DATA_W-1:0] rd_value;
    logic              unused_addr_bits;

`ifdef LB_FIFO_CSR_IRQ_EN
    logic [IRQ_EN_W-1:0] irq_en_q, irq_en_d;
    logic [IRQ_EN_W-1:0] irq_src;
    logic [IRQ_EN_W-1:0] irq_masked;
    logic                irq_q, irq_d;
`endif

    // Only the low byte of the address selects a register
    assign unused_addr_bits = ^{lb_waddr[ADDR_W-1:OFF_W], lb_raddr[ADDR_W-1:OFF_W]};

    assign wr_sel    = decode_offset(lb_waddr[OFF_W-1:0]);
    assign rd_sel    = decode_offset(lb_raddr[OFF_W-1:0]);

    assign lb_wready = !((wr_sel == REG_TXDATA) && tx_full);
    assign wr_fire   = lb_wen && lb_wready;
    assign strb_all  = &lb_wstrb;
    assign ctrl_wr   = wr_fire && (wr_sel == REG_CTRL) && lb_wstrb[0];

    // A read is accepted when lb_ren is high and no response is on the bus;
    // the cycle carrying lb_rvalid never starts a new read.
    assign rd_accept = lb_ren && !lb_rvalid_q;

    assign tx_push   = wr_fire && (wr_sel == REG_TXDATA) && strb_all;
    assign tx_pop    = tx_valid && tx_ready;
    assign tx_flush  = ctrl_wr && lb_wdata[CTRL_TX_FLUSH];
    assign tx_valid  = !tx_empty;
    assign tx_data   = tx_head;

    assign rx_ready  = rx_en_q && !rx_full;
    assign rx_push   = rx_valid && rx_ready;
    assign rx_pop    = rd_accept && (rd_sel == REG_RXDATA) && !rx_empty;
    assign rx_flush  = ctrl_wr && lb_wdata[CTRL_RX_FLUSH];

    assign lb_rvalid = lb_rvalid_q;
    assign lb_rdata  = lb_rdata_q;

    lb_fifo_sync #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_tx_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (tx_flush),
        .push      (tx_push),
        .push_data (lb_wdata),
        .pop       (tx_pop),
        .head_data (tx_head),
        .count     (tx_count),
        .full      (tx_full),
        .empty     (tx_empty)
    );

    lb_fifo_sync #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_rx_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (rx_flush),
        .push      (rx_push),
        .push_data (rx_data),
        .pop       (rx_pop),
        .head_data (rx_head),
        .count     (rx_count),
        .full      (rx_full),
        .empty     (rx_empty)
    );

    // Pack the STATUS word from FIFO state and the sticky flags
    always_comb begin
        status_word = '0;
        status_word[ST_TX_COUNT_LSB +: ST_COUNT_W] = ST_COUNT_W'(tx_count);
        status_word[ST_RX_COUNT_LSB +: ST_COUNT_W] = ST_COUNT_W'(rx_count);
        status_word[ST_TX_FULL]  = tx_full;
        status_word[ST_RX_EMPTY] = rx_empty;
        status_word[ST_RXUF]     = rxuf_q;
        status_word[ST_RXOF]     = rxof_q;
        status_word[ST_WERR]     = werr_q;
    end

    // Read mux: value returned for the currently addressed register
    always_comb begin
        rd_value = '0;
        case (rd_sel)
            REG_RXDATA: rd_value = rx_empty ? '0 : rx_head;
            REG_STATUS: rd_value = status_word;
            REG_CTRL:   rd_value[CTRL_RX_EN] = rx_en_q;
`ifdef LB_FIFO_CSR_IRQ_EN
            REG_IRQ_EN: rd_value[IRQ_EN_W-1:0] = irq_en_q;
`endif
            default:    rd_value = '0;
        endcase
    end

    // Next-state for control bits, sticky flags and the read response.
    // A STATUS read clears the sticky flags, but an event in the same cycle
    // sets them again so it is never lost.
    always_comb begin
        rx_en_d     = ctrl_wr ? lb_wdata[CTRL_RX_EN] : rx_en_q;

        rxuf_d      = (rd_accept && (rd_sel == REG_STATUS)) ? 1'b0 : rxuf_q;
        rxof_d      = (rd_accept && (rd_sel == REG_STATUS)) ? 1'b0 : rxof_q;
        werr_d      = (rd_accept && (rd_sel == REG_STATUS)) ? 1'b0 : werr_q;
        if (rd_accept && (rd_sel == REG_RXDATA) && rx_empty) begin
            rxuf_d = 1'b1;
        end
        if (rx_valid && rx_en_q && rx_full) begin
            rxof_d = 1'b1;
        end
        if (wr_fire && (wr_sel == REG_TXDATA) && !strb_all) begin
            werr_d = 1'b1;
        end

        lb_rvalid_d = rd_accept;
        lb_rdata_d  = rd_accept ? rd_value : '0;
    end

    // CSR state registers
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_en_q     <= 1'b1;
            rxuf_q      <= 1'b0;
            rxof_q      <= 1'b0;
            werr_q      <= 1'b0;
            lb_rvalid_q <= 1'b0;
            lb_rdata_q  <= '0;
        end else begin
            rx_en_q     <= rx_en_d;
            rxuf_q      <= rxuf_d;
            rxof_q      <= rxof_d;
            werr_q      <= werr_d;
            lb_rvalid_q <= lb_rvalid_d;
            lb_rdata_q  <= lb_rdata_d;
        end
    end

`ifdef LB_FIFO_CSR_IRQ_EN
    assign irq_src[IRQ_RX_NOT_EMPTY] = !rx_empty;
    assign irq_src[IRQ_TX_EMPTY]     = tx_empty;
    assign irq_src[IRQ_ERR]          = rxuf_q | rxof_q | werr_q;

    for (genvar gi = 0; gi < IRQ_EN_W; gi++) begin : g_irq_mask
        assign irq_masked[gi] = irq_en_q[gi] & irq_src[gi];
    end

    // Interrupt enable register update and registered interrupt
    always_comb begin
        irq_en_d = irq_en_q;
        if (wr_fire && (wr_sel == REG_IRQ_EN) && lb_wstrb[0]) begin
            irq_en_d = lb_wdata[IRQ_EN_W-1:0];
        end
        irq_d = |irq_masked;
    end

    // Interrupt registers
    always_ff @(posedge clk) begin
        if (rst) begin
            irq_en_q <= '0;
            irq_q    <= 1'b0;
        end else begin
            irq_en_q <= irq_en_d;
            irq_q    <= irq_d;
        end
    end

    assign irq = irq_q;
`endif

endmodule

// File: tb/tb_lb_fifo_csr.sv
// Directed bench for lb_fifo_csr. Read expectations and TX stream
// expectations are queued by the stimulus thread and consumed by monitors
// that compare whenever lb_rvalid or a tx handshake is seen.
`timescale 1ns/1ps
module tb_lb_fifo_csr;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] lb_waddr, lb_wdata, lb_raddr, lb_rdata;
    logic [3:0]  lb_wstrb;
    logic        lb_wen, lb_wready, lb_ren, lb_rvalid;
    logic [31:0] tx_data, rx_data;
    logic        tx_valid, tx_ready, rx_valid, rx_ready;
`ifdef LB_FIFO_CSR_IRQ_EN
    logic        irq;
`endif

    typedef struct {
        string       name;
        logic [31:0] val;
    } exp_t;

    exp_t        rd_exp[$];
    logic [31:0] tx_exp[$];
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    lb_fifo_csr #(.ADDR_W(32), .DATA_W(32), .DEPTH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .lb_waddr  (lb_waddr),
        .lb_wdata  (lb_wdata),
        .lb_wen    (lb_wen),
        .lb_wstrb  (lb_wstrb),
        .lb_wready (lb_wready),
        .lb_raddr  (lb_raddr),
        .lb_ren    (lb_ren),
        .lb_rdata  (lb_rdata),
        .lb_rvalid (lb_rvalid),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready)
`ifdef LB_FIFO_CSR_IRQ_EN
        ,
        .irq       (irq)
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%08h required=%08h", name, act, req);
        end else begin
            $display("ok   %s value=%08h", name, act);
        end
    endtask

    // Read-response monitor
    always @(negedge clk) begin
        if (lb_rvalid === 1'b1) begin
            if (rd_exp.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rd_unexpected actual=%08h required=no_response", lb_rdata);
            end else begin
                exp_t e;
                e = rd_exp.pop_front();
                check(e.name, lb_rdata, e.val);
            end
        end
    end

    // TX stream monitor: a handshake seen here completes on the next edge
    always @(negedge clk) begin
        if (tx_valid === 1'b1 && tx_ready === 1'b1) begin
            if (tx_exp.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL tx_unexpected actual=%08h required=no_transfer", tx_data);
            end else begin
                logic [31:0] e;
                e = tx_exp.pop_front();
                check("tx_stream", tx_data, e);
            end
        end
    end

    // All stimulus tasks start and end at posedge+1
    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic lb_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s);
        int n;
        lb_waddr = {24'h0, a};
        lb_wdata = d;
        lb_wstrb = s;
        lb_wen   = 1'b1;
        n = 0;
        @(negedge clk);
        while (lb_wready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) begin
            checks++;
            errors++;
            $display("FAIL wr_timeout addr=%02h actual=stalled required=wready", a);
        end
        @(posedge clk);
        #1;
        lb_wen = 1'b0;
    endtask

    task automatic lb_read(input string name, input logic [7:0] a, input logic [31:0] req);
        int   n;
        exp_t e;
        e.name = name;
        e.val  = req;
        rd_exp.push_back(e);
        lb_raddr = {24'h0, a};
        lb_ren   = 1'b1;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (lb_rvalid !== 1'b1 && n < 20);
        check({name, "_latency"}, n, 1);
        lb_ren = 1'b0;
        @(posedge clk);
        #1;
        check({name, "_idle_rdata"}, {lb_rdata[31:1], lb_rvalid}, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        lb_waddr = '0; lb_wdata = '0; lb_wstrb = '0; lb_wen = 1'b0;
        lb_raddr = '0; lb_ren = 1'b0;
        tx_ready = 1'b0; rx_data = '0; rx_valid = 1'b0;
        cyc(3);
        @(negedge clk);
        check("rst_rvalid", lb_rvalid, 0);
        check("rst_rdata", lb_rdata, 0);
        check("rst_tx_valid", tx_valid, 0);
        check("rst_wready", lb_wready, 1);
        check("rst_rx_ready", rx_ready, 1);
        @(posedge clk); #1;
        rst = 1'b0;

        lb_read("rst_status", 8'h08, 32'h0002_0000);
        lb_read("rst_ctrl", 8'h0C, 32'h0000_0004);

        // Single TX write with tx_ready high
        tx_ready = 1'b1;
        tx_exp.push_back(32'hDEAD_BEEF);
        lb_write(8'h00, 32'hDEAD_BEEF, 4'hF);
        check("tx_valid_rise", tx_valid, 1);
        check("tx_data_head", tx_data, 32'hDEAD_BEEF);
        cyc(1);
        check("tx_valid_drop", tx_valid, 0);

        // Fill TX with tx_ready low, then a 9th write stalls
        tx_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tx_exp.push_back(32'h100 + i);
            lb_write(8'h00, 32'h100 + i, 4'hF);
        end
        lb_read("tx_full_status", 8'h08, 32'h0003_0008);
        tx_exp.push_back(32'h108);
        lb_waddr = 32'h0; lb_wdata = 32'h108; lb_wstrb = 4'hF; lb_wen = 1'b1;
        @(negedge clk);
        check("stall_wready", lb_wready, 0);
        @(posedge clk); #1;
        tx_ready = 1'b1;
        @(negedge clk);
        check("stall_hold", lb_wready, 0);
        @(posedge clk); #1;
        tx_ready = 1'b0;
        @(negedge clk);
        check("stall_release", lb_wready, 1);
        @(posedge clk); #1;
        lb_wen = 1'b0;
        lb_read("ninth_status", 8'h08, 32'h0003_0008);
        tx_ready = 1'b1;
        cyc(10);
        tx_ready = 1'b0;
        check("tx_drained", tx_exp.size(), 0);
        check("tx_empty_after_drain", tx_valid, 0);

        // Partial-strobe TXDATA write is discarded and flagged
        lb_write(8'h00, 32'hCAFE_BABE, 4'h6);
        check("partial_no_push", tx_valid, 0);
        lb_read("werr_status", 8'h08, 32'h0012_0000);
        lb_read("werr_cleared", 8'h08, 32'h0002_0000);

        // RX single entry, then underflow
        rx_data = 32'hC0DE_BABE; rx_valid = 1'b1;
        cyc(1);
        rx_valid = 1'b0;
        lb_read("rx_data", 8'h04, 32'hC0DE_BABE);
        lb_read("rx_underflow", 8'h04, 32'h0);
        lb_read("rxuf_status", 8'h08, 32'h0006_0000);
        lb_read("rxuf_cleared", 8'h08, 32'h0002_0000);

        // CTRL byte strobes, rx_en, unmapped offsets
        lb_write(8'h0C, 32'h0, 4'hE);
        lb_read("ctrl_unstrobed", 8'h0C, 32'h4);
        lb_write(8'h0C, 32'h0, 4'h1);
        check("rx_en_off_ready", rx_ready, 0);
        lb_read("ctrl_rx_en_off", 8'h0C, 32'h0);
        lb_write(8'h0C, 32'h4, 4'h1);
        lb_write(8'h20, 32'hFFFF_FFFF, 4'hF);
        lb_read("ctrl_after_unmapped", 8'h0C, 32'h4);
        lb_write(8'h10, 32'h7, 4'hF);
`ifdef LB_FIFO_CSR_IRQ_EN
        lb_read("irq_en_reg", 8'h10, 32'h7);
        lb_write(8'h10, 32'h0, 4'hF);
`else
        lb_read("irq_en_absent", 8'h10, 32'h0);
`endif

        // Fill RX, overflow, then flush while rx_valid stays high
        for (int i = 0; i < 8; i++) begin
            rx_data = 32'hA0 + i; rx_valid = 1'b1;
            cyc(1);
        end
        rx_data = 32'h5A5A_0001;
        @(negedge clk);
        check("rx_full_ready", rx_ready, 0);
        cyc(2);
        lb_read("rx_full_status", 8'h08, 32'h0008_0800);
        lb_write(8'h0C, 32'h6, 4'hF);
        @(negedge clk);
        check("rx_flushed_ready", rx_ready, 1);
        @(posedge clk); #1;
        rx_valid = 1'b0;
        lb_read("rxof_status", 8'h08, 32'h0008_0100);
        lb_read("rx_resumed", 8'h04, 32'h5A5A_0001);
        lb_read("rxof_cleared", 8'h08, 32'h0002_0000);

        // Reset while a read is pending
        rx_data = 32'h77; rx_valid = 1'b1;
        cyc(1);
        rx_valid = 1'b0;
        lb_raddr = 32'h4; lb_ren = 1'b1; rst = 1'b1;
        @(posedge clk); #1;
        lb_ren = 1'b0;
        @(negedge clk);
        check("midrst_rvalid", lb_rvalid, 0);
        check("midrst_rdata", lb_rdata, 0);
        check("midrst_wready", lb_wready, 1);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("postrst_rvalid", lb_rvalid, 0);
        @(posedge clk); #1;
        lb_read("postrst_status", 8'h08, 32'h0002_0000);
        lb_read("postrst_ctrl", 8'h0C, 32'h4);

        cyc(2);
        check("rd_queue_empty", rd_exp.size(), 0);
        check("tx_queue_empty", tx_exp.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/lb_fifo_csr.md
LB_FIFO_CSR -- requirements
Module: lb_fifo_csr

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, local-bus address width.
REQ-002 SHALL have parameter DATA_W, default 32, data width; STRB_W = DATA_W/8.
REQ-003 SHALL have parameter DEPTH, default 8, entries per FIFO; power of two, at least 2.
REQ-004 SHALL have ports clk input 1 clock; rst input 1 reset, synchronous, active-high; one clock domain only.
REQ-005 SHALL have ports lb_waddr in ADDR_W; lb_wdata in DATA_W; lb_wen in 1; lb_wstrb in STRB_W; lb_wready out 1.
REQ-006 SHALL have ports lb_raddr in ADDR_W; lb_ren in 1; lb_rdata out DATA_W; lb_rvalid out 1.
REQ-007 SHALL have ports tx_data out DATA_W; tx_valid out 1; tx_ready in 1, the outbound stream.
REQ-008 SHALL have ports rx_data in DATA_W; rx_valid in 1; rx_ready out 1, the inbound stream.

Function
REQ-009 SHALL decode register offsets from lb_*addr[7:0]: 0x00 TXDATA (W), 0x04 RXDATA (R), 0x08 STATUS (R), 0x0C CTRL (RW).
REQ-010 SHALL complete a write in the cycle where lb_wen && lb_wready is true.
REQ-011 SHALL hold lb_wready low while TXDATA is addressed and the TX FIFO is full; lb_wready SHALL otherwise be high.
REQ-012 SHALL push lb_wdata into the TX FIFO on a completed TXDATA write with all strobes set; a partial-strobe TXDATA write SHALL be discarded and SHALL set sticky STATUS.werr.
REQ-013 SHALL apply lb_wstrb per byte on CTRL writes; unmapped-offset writes SHALL complete with no effect.
REQ-014 SHALL treat lb_ren as held until lb_rvalid; it SHALL assert lb_rvalid as a one-cycle pulse exactly one cycle after lb_ren is first sampled high, and SHALL drive lb_rdata to 0 when lb_rvalid is low.
REQ-015 SHALL pop exactly one RX entry per RXDATA read transaction; an RXDATA read while the RX FIFO is empty SHALL return 0 and set sticky STATUS.rxuf.
REQ-016 SHALL pack STATUS as [7:0] tx_count, [15:8] rx_count, [16] tx_full, [17] rx_empty, [18] rxuf, [19] rxof, [20] werr; reading STATUS SHALL clear bits 18-20 in the same cycle that lb_rvalid asserts.
REQ-017 SHALL assign CTRL bits: [0] tx_flush and [1] rx_flush are self-clearing one-cycle pulses that empty the FIFO; [2] rx_en, reset value 1; reads SHALL return bit 2 only.
REQ-018 SHALL drive tx_valid = TX FIFO not empty and tx_data = head entry; an entry SHALL pop on tx_valid && tx_ready.
REQ-019 SHALL drive rx_ready = rx_en && RX FIFO not full; an entry SHALL be pushed on rx_valid && rx_ready.
REQ-020 SHALL set sticky rxof when rx_valid is high and rx_en=1 while the RX FIFO is full; the data SHALL not be accepted.
REQ-021 SHALL support a simultaneous push and pop on a full or empty FIFO: full allows push only when a pop occurs in the same cycle; empty forbids pop; the count SHALL be unchanged on a push-pop cycle.
REQ-022 SHALL let flush dominate a same-cycle push or pop; the count after a flush SHALL be 0.
REQ-023 SHALL count with $clog2(DEPTH)+1 bits and wrap pointers modulo DEPTH.

Reset
REQ-024 SHALL on rst clear both FIFOs, clear the sticky flags, set rx_en=1, and drive lb_rvalid=0, lb_rdata=0, tx_valid=0, lb_wready=1; reset mid-transaction SHALL abandon it with no pop.

Configuration
REQ-025 With LB_FIFO_CSR_IRQ_EN defined, the block SHALL add output irq (1 bit) and register IRQ_EN at 0x10 (bits [0] rx_not_empty, [1] tx_empty, [2] any sticky error; reset 0); irq SHALL be the registered OR of enabled sources, one cycle latency. Without the macro, 0x10 SHALL read 0 and ignore writes, and no irq port SHALL exist.

Structure
REQ-026 SHALL place register offsets, STATUS/CTRL bit indices and field widths in package lb_fifo_csr_pkg.
REQ-027 SHALL instantiate sub-module lb_fifo_sync (synchronous FIFO with count, full, empty and flush) twice, once for TX and once for RX.

Verification
REQ-028 The bench SHALL write 0xDEADBEEF to 0x00 with strobe 0xF and tx_ready=1 -> tx_valid rises and tx_data=0xDEADBEEF.
REQ-029 The bench SHALL perform 9 TXDATA writes with tx_ready=0 and DEPTH=8 -> the 9th write stalls with lb_wready=0; releasing tx_ready for one cycle completes it; tx_count=8.
REQ-030 The bench SHALL drive rx_data=0xC0DEBABE, then read 0x04 -> lb_rvalid arrives 1 cycle after lb_ren with data 0xC0DEBABE; a second read returns 0 and STATUS[18]=1, cleared by that STATUS read.
REQ-031 The bench SHALL write 0xCAFEBABE to 0x00 with strobe 0x6 -> no TX push and STATUS[20]=1.
REQ-032 The bench SHALL fill RX with 8 entries, keep rx_valid high, then write CTRL=0x6 -> rxof=1 and rx_count=0 next cycle, and accepted data resumes.
REQ-033 The bench SHALL assert rst during a pending read -> lb_rvalid=0, counts=0 and no pop.
